lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store unit in the MEM stage of the pipelined RV32I core.
- Takes a load or store request from the EX/MEM pipeline register and derives byte enables and lane-replicated store data.
- Runs a request/grant/response handshake with the data memory, then returns aligned, sign- or zero-extended load data to the MEM/WB register.
- Holds the pipeline via stall while a memory access is outstanding.

Parameters:
- XLEN, 32, data width.
- ADDR_SIZE, 32, address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  MEM stage holds a load/store.
- req_we  in  1  1=store, 0=load.
- req_swhb  in  2  access width: 01 word, 10 half, 11 byte.
- req_lunsigned  in  1  zero-extend load (lbu/lhu).
- req_addr  in  ADDR_SIZE  byte address.
- req_wdata  in  XLEN  store data (low bits significant).
- flush  in  1  kill the current MEM instruction.
- stall  out  1  freeze PC and pipeline registers.
- rsp_valid  out  1  one-cycle pulse, load data valid.
- rsp_rdata  out  XLEN  extended load result.
- misalign  out  1  one-cycle pulse, misaligned access rejected.
- dmem_req  out  1  memory request.
- dmem_gnt  in  1  memory accepted the request.
- dmem_we  out  1  write.
- dmem_be  out  4  byte enables.
- dmem_addr  out  ADDR_SIZE  word address ({addr[31:2],2'b00}).
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  XLEN  raw read word.

Behaviour:
- Reset: state IDLE; all outputs 0; captured request registers 0. Reset mid-access abandons it; a late dmem_rvalid is ignored once in IDLE.
- FSM states: IDLE, REQ, WAIT, DONE.
- Misalign rule: half with addr[0]=1, or word with addr[1:0]!=0.
- IDLE, req_valid & !flush & misaligned: misalign=1 for this cycle only; no dmem_req; stall=0; stay IDLE.
- IDLE, req_valid & !flush & aligned: register addr, we, swhb, lunsigned, be and wdata; stall=1 (combinational); next state REQ.
- REQ: dmem_req=1 with registered fields, held stable until dmem_gnt. On gnt, a store goes to DONE and a load goes to WAIT. flush before gnt: drop dmem_req, go to IDLE with no response.
- WAIT: stall=1. On dmem_rvalid, capture the extended data and go to DONE. flush in WAIT sets a kill flag; the response is still absorbed, then DONE issues no rsp_valid.
- DONE: stall=0; rsp_valid=1 for an unkilled load; next state IDLE. req_valid in DONE is the retiring instruction and is ignored.
- stall = (IDLE & req_valid & !flush & aligned) | REQ | WAIT.
- Minimum latency with gnt in the first REQ cycle and rvalid one cycle after gnt: store 3 cycles, load 4 cycles. dmem_rvalid never arrives in the same cycle as gnt.
- Byte enables:
  - word: 1111.
  - half: addr[1] ? 1100 : 0011.
  - byte: one-hot by addr[1:0] (00→0001 ... 11→1000).
- Store data:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- Load extract: shift dmem_rdata right by 8*addr[1:0], take 8/16/32 bits, sign-extend unless lunsigned. rsp_rdata holds its value until the next load completes.

Decomposition:
- Shared defines header: XLEN, ADDR_SIZE, width codes (SWHB_WORD=01, SWHB_HALF=10, SWHB_BYTE=11), FSM state encodings.
- One sub-module, lsu_load_align: combinational lane select plus sign/zero extension, reused later by the cache refill path.

Test Plan:
- sb addr 0x80000003, wdata 0x000000AB, gnt immediate → dmem_addr 0x80000000, be 1000, wdata 0xABABABAB, we=1; stall high 2 cycles then 0; no rsp_valid.
- lb addr 0x80000102, rdata 0x1280FF34 → rsp_rdata 0xFFFFFF80; repeated as lbu → 0x00000080; rsp_valid single pulse in DONE.
- lh addr 0x80000002, rdata 0x80011234 → 0xFFFF8001; lw addr 0x80000002 → misalign pulse, dmem_req never asserted, stall 0.
- lw with gnt delayed 3 cycles and rvalid 2 cycles after gnt → stall high 7 cycles; dmem_addr/be stable through REQ; rsp_rdata equals dmem_rdata.
- flush during WAIT → rvalid absorbed, no rsp_valid, back to IDLE; next request serviced normally.
- reset asserted in WAIT → all outputs 0 immediately; subsequent stray dmem_rvalid produces no rsp_valid.

Source files
------------

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared widths, access-size codes, FSM encoding and lane helpers for the
// MEM-stage load/store unit.
package lsu_mem_ctrl_pkg;

  localparam int XLEN      = 32;
  localparam int ADDR_SIZE = 32;

  typedef enum logic [1:0] {
    SWHB_NONE = 2'b00,
    SWHB_WORD = 2'b01,
    SWHB_HALF = 2'b10,
    SWHB_BYTE = 2'b11
  } swhb_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] swhb, input logic [1:0] lo);
    return ((swhb == SWHB_HALF) && lo[0]) || ((swhb == SWHB_WORD) && (lo != 2'b00));
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] swhb, input logic [1:0] lo);
    logic [3:0] be;
    case (swhb)
      SWHB_BYTE: be = 4'b0001 << lo;
      SWHB_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

  // Stores are replicated across all lanes so the byte enables alone pick the target.
  function automatic logic [XLEN-1:0] lane_replicate(input logic [1:0] swhb,
                                                     input logic [XLEN-1:0] wdata);
    logic [XLEN-1:0] rep;
    case (swhb)
      SWHB_BYTE: rep = {4{wdata[7:0]}};
      SWHB_HALF: rep = {2{wdata[15:0]}};
      default:   rep = wdata;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// Load lane select plus sign/zero extension; purely combinational so the
// cache refill path can share it.
module lsu_load_align #(
  parameter int XLEN = lsu_mem_ctrl_pkg::XLEN
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      lane,
  input  logic [1:0]      swhb,
  input  logic            lunsigned,
  output logic [XLEN-1:0] data
);
  import lsu_mem_ctrl_pkg::*;

  logic [XLEN-1:0] shifted;
  logic            sign_bit;

  assign shifted = rdata >> {lane, 3'b000};

  always_comb begin
    data     = shifted;
    sign_bit = 1'b0;
    case (swhb)
      SWHB_BYTE: begin
        sign_bit = shifted[7] & ~lunsigned;
        data     = {{(XLEN-8){sign_bit}}, shifted[7:0]};
      end
      SWHB_HALF: begin
        sign_bit = shifted[15] & ~lunsigned;
        data     = {{(XLEN-16){sign_bit}}, shifted[15:0]};
      end
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store unit: captures a request, runs the req/gnt/rvalid
// handshake with data memory and returns extended load data.
module lsu_mem_ctrl #(
  parameter int XLEN      = lsu_mem_ctrl_pkg::XLEN,
  parameter int ADDR_SIZE = lsu_mem_ctrl_pkg::ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 req_we,
  input  logic [1:0]           req_swhb,
  input  logic                 req_lunsigned,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [XLEN-1:0]      req_wdata,
  input  logic                 flush,
  output logic                 stall,
  output logic                 rsp_valid,
  output logic [XLEN-1:0]      rsp_rdata,
  output logic                 misalign,
  output logic                 dmem_req,
  input  logic                 dmem_gnt,
  output logic                 dmem_we,
  output logic [3:0]           dmem_be,
  output logic [ADDR_SIZE-1:0] dmem_addr,
  output logic [XLEN-1:0]      dmem_wdata,
  input  logic                 dmem_rvalid,
  input  logic [XLEN-1:0]      dmem_rdata
);
  import lsu_mem_ctrl_pkg::*;

  state_e               state;
  logic                 we_q, lunsigned_q, kill_q;
  logic [1:0]           swhb_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [3:0]           be_q;
  logic [XLEN-1:0]      wdata_q, rdata_q, load_ext;
  logic                 bad_align, accept;

  assign bad_align = is_misaligned(req_swhb, req_addr[1:0]);
  assign accept    = (state == ST_IDLE) && req_valid && !flush && !bad_align;
  assign misalign  = (state == ST_IDLE) && req_valid && !flush && bad_align;
  assign stall     = accept || (state == ST_REQ) || (state == ST_WAIT);

  // A flush while still requesting withdraws the request in the same cycle.
  assign dmem_req   = (state == ST_REQ) && !flush;
  assign dmem_we    = we_q;
  assign dmem_be    = be_q;
  assign dmem_addr  = {addr_q[ADDR_SIZE-1:2], 2'b00};
  assign dmem_wdata = wdata_q;
  assign rsp_valid  = (state == ST_DONE) && !we_q && !kill_q;
  assign rsp_rdata  = rdata_q;

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .rdata     (dmem_rdata),
    .lane      (addr_q[1:0]),
    .swhb      (swhb_q),
    .lunsigned (lunsigned_q),
    .data      (load_ext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      we_q        <= 1'b0;
      lunsigned_q <= 1'b0;
      kill_q      <= 1'b0;
      swhb_q      <= 2'b00;
      addr_q      <= '0;
      be_q        <= 4'b0000;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          kill_q <= 1'b0;
          if (accept) begin
            we_q        <= req_we;
            lunsigned_q <= req_lunsigned;
            swhb_q      <= req_swhb;
            addr_q      <= req_addr;
            be_q        <= byte_enables(req_swhb, req_addr[1:0]);
            wdata_q     <= lane_replicate(req_swhb, req_wdata);
            state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (flush)         state <= ST_IDLE;
          else if (dmem_gnt) state <= we_q ? ST_DONE : ST_WAIT;
        end
        ST_WAIT: begin
          // A killed load still drains its response but must not update rsp_rdata.
          if (flush) kill_q <= 1'b1;
          if (dmem_rvalid) begin
            if (!kill_q && !flush) rdata_q <= load_ext;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: stores, loads of every width, misalign,
// slow memory, flushes and reset during an outstanding access.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, req_lunsigned, flush;
  logic [1:0]  req_swhb;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid, misalign, dmem_req, dmem_gnt, dmem_we, dmem_rvalid;
  logic [31:0] rsp_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  int n_cmp = 0;
  int n_bad = 0;

  int          stall_cnt, rsp_cnt, mis_cnt, req_seen, unstable;
  logic [31:0] rsp_val, first_addr, first_wdata;
  logic [3:0]  first_be;
  logic        first_we;

  always #5 clk = ~clk;

  lsu_mem_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_swhb      (req_swhb),
    .req_lunsigned (req_lunsigned),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .flush         (flush),
    .stall         (stall),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .misalign      (misalign),
    .dmem_req      (dmem_req),
    .dmem_gnt      (dmem_gnt),
    .dmem_we       (dmem_we),
    .dmem_be       (dmem_be),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one access for a bounded number of cycles acting as the memory:
  // grant after gnt_dly requesting cycles, read data rv_dly cycles after grant.
  task automatic access(input logic we, input logic [1:0] swhb, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int gnt_dly,
                        input int rv_dly, input int flush_at);
    int gnt_at;
    int ncyc;
    gnt_at = -1;
    ncyc   = gnt_dly + rv_dly + 5;
    stall_cnt = 0; rsp_cnt = 0; mis_cnt = 0; req_seen = 0; unstable = 0;
    rsp_val = 32'h0; first_addr = 32'h0; first_be = 4'h0; first_wdata = 32'h0; first_we = 1'b0;
    req_valid = 1'b1; req_we = we; req_swhb = swhb; req_lunsigned = uns;
    req_addr = addr; req_wdata = wdata;
    for (int c = 0; c < ncyc; c++) begin
      flush       = (c == flush_at);
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      if (!we && gnt_at >= 0 && c == gnt_at + rv_dly) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
      end
      #1;
      if (dmem_req) begin
        if (req_seen == 0) begin
          first_addr = dmem_addr; first_be = dmem_be;
          first_wdata = dmem_wdata; first_we = dmem_we;
        end else if (dmem_addr !== first_addr || dmem_be !== first_be) begin
          unstable++;
        end
        if (req_seen == gnt_dly) begin
          dmem_gnt = 1'b1;
          gnt_at   = c;
        end
        req_seen++;
      end
      #1;
      if (stall) stall_cnt++;
      if (misalign) mis_cnt++;
      if (rsp_valid) begin
        rsp_cnt++;
        rsp_val = rsp_rdata;
      end
      if (misalign || flush || (!stall && c > 0)) req_valid = 1'b0;
      tick();
    end
    flush = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_swhb = 2'b00; req_lunsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; flush = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    tick();
    tick();
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_req", {31'h0, dmem_req}, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_be", {28'h0, dmem_be}, 32'h0);
    check("rst_rdata", rsp_rdata, 32'h0);
    reset = 1'b0;
    tick();

    // sb 0x80000003
    access(1'b1, 2'b11, 1'b0, 32'h8000_0003, 32'h0000_00AB, 32'h0, 0, 0, -1);
    check("sb_addr", first_addr, 32'h8000_0000);
    check("sb_be", {28'h0, first_be}, 32'h8);
    check("sb_wdata", first_wdata, 32'hABAB_ABAB);
    check("sb_we", {31'h0, first_we}, 32'h1);
    check("sb_stall", stall_cnt, 32'd2);
    check("sb_rsp", rsp_cnt, 32'd0);

    // lb / lbu 0x80000102
    access(1'b0, 2'b11, 1'b0, 32'h8000_0102, 32'h0, 32'h1280_FF34, 0, 1, -1);
    check("lb_be", {28'h0, first_be}, 32'h4);
    check("lb_addr", first_addr, 32'h8000_0100);
    check("lb_rsp_cnt", rsp_cnt, 32'd1);
    check("lb_data", rsp_val, 32'hFFFF_FF80);
    check("lb_stall", stall_cnt, 32'd3);
    check("lb_hold", rsp_rdata, 32'hFFFF_FF80);
    access(1'b0, 2'b11, 1'b1, 32'h8000_0102, 32'h0, 32'h1280_FF34, 0, 1, -1);
    check("lbu_rsp_cnt", rsp_cnt, 32'd1);
    check("lbu_data", rsp_val, 32'h0000_0080);

    // lh 0x80000002, then misaligned lw at the same address
    access(1'b0, 2'b10, 1'b0, 32'h8000_0002, 32'h0, 32'h8001_1234, 0, 1, -1);
    check("lh_be", {28'h0, first_be}, 32'hC);
    check("lh_data", rsp_val, 32'hFFFF_8001);
    access(1'b0, 2'b01, 1'b0, 32'h8000_0002, 32'h0, 32'h0, 0, 1, -1);
    check("mis_pulse", mis_cnt, 32'd1);
    check("mis_req", req_seen, 32'd0);
    check("mis_stall", stall_cnt, 32'd0);
    check("mis_rsp", rsp_cnt, 32'd0);

    // sh 0x80000006
    access(1'b1, 2'b10, 1'b0, 32'h8000_0006, 32'h0000_BEEF, 32'h0, 0, 0, -1);
    check("sh_be", {28'h0, first_be}, 32'hC);
    check("sh_wdata", first_wdata, 32'hBEEF_BEEF);
    check("sh_addr", first_addr, 32'h8000_0004);

    // lw with slow grant and slow data
    access(1'b0, 2'b01, 1'b0, 32'h8000_0020, 32'h0, 32'hCAFE_F00D, 3, 2, -1);
    check("lw_slow_stall", stall_cnt, 32'd7);
    check("lw_slow_stable", unstable, 32'd0);
    check("lw_slow_req", req_seen, 32'd4);
    check("lw_slow_be", {28'h0, first_be}, 32'hF);
    check("lw_slow_data", rsp_val, 32'hCAFE_F00D);

    // flush during WAIT, then a normal lhu
    access(1'b0, 2'b01, 1'b0, 32'h8000_0040, 32'h0, 32'h1111_1111, 0, 2, 2);
    check("flw_rsp", rsp_cnt, 32'd0);
    check("flw_stall", stall_cnt, 32'd4);
    check("flw_hold", rsp_rdata, 32'hCAFE_F00D);
    access(1'b0, 2'b10, 1'b1, 32'h8000_0046, 32'h0, 32'h9ABC_5678, 0, 1, -1);
    check("lhu_rsp_cnt", rsp_cnt, 32'd1);
    check("lhu_data", rsp_val, 32'h0000_9ABC);

    // flush while requesting
    access(1'b1, 2'b01, 1'b0, 32'h8000_0008, 32'h1234_5678, 32'h0, 5, 0, 1);
    check("flr_req", req_seen, 32'd0);
    check("flr_stall", stall_cnt, 32'd2);

    // reset while a load waits for data
    req_valid = 1'b1; req_we = 1'b0; req_swhb = 2'b01; req_lunsigned = 1'b0;
    req_addr = 32'h8000_0010;
    #1;
    tick();
    dmem_gnt = 1'b1;
    #1;
    check("rw_req", {31'h0, dmem_req}, 32'h1);
    tick();
    dmem_gnt = 1'b0;
    #1;
    check("rw_stall_wait", {31'h0, stall}, 32'h1);
    reset = 1'b1;
    req_valid = 1'b0;
    #1;
    check("rw_stall", {31'h0, stall}, 32'h0);
    check("rw_req0", {31'h0, dmem_req}, 32'h0);
    check("rw_addr", dmem_addr, 32'h0);
    check("rw_be", {28'h0, dmem_be}, 32'h0);
    check("rw_rdata", rsp_rdata, 32'h0);
    tick();
    reset = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEAD_BEEF;
    #1;
    check("rw_stray_rsp", {31'h0, rsp_valid}, 32'h0);
    tick();
    dmem_rvalid = 1'b0;
    #1;
    check("rw_after_rsp", {31'h0, rsp_valid}, 32'h0);
    check("rw_after_rdata", rsp_rdata, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
